// File: rtl/regbank4_w1h.sv
// ---------------------------------------------------------------------------
// regbank4_w1h
//   Four-entry register bank placed after a 2-to-4 enable decoder. A one-hot
//   write select stores wr_data into the selected entry and sets its valid
//   bit. A select with two or more bits set is rejected: nothing is written,
//   and a sticky error flag is raised. Two independent read ports return the
//   stored entries combinationally. Accepted writes are counted, and the
//   count saturates at 255.
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset (clears data, valid, error, count)
//   we_onehot   write select, bit i selects entry i
//   wr_data     write data
//   clr_valid   clears all valid bits (a concurrent write re-validates its entry)
//   err_clr     clears sel_err (a concurrent multi-hot select wins)
//   rd_addr_a   read port A address
//   rd_addr_b   read port B address
//   rd_data_a   entry rd_addr_a
//   rd_data_b   entry rd_addr_b
//   rd_valid_a  valid bit of entry rd_addr_a
//   rd_valid_b  valid bit of entry rd_addr_b
//   sel_err     sticky multi-hot select error
//   wr_cnt      saturating count of accepted writes
// ---------------------------------------------------------------------------
module regbank4_w1h #(
    parameter int WIDTH = 8,
    parameter int DELAY = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       we_onehot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_valid,
    input  logic             err_clr,
    input  logic [1:0]       rd_addr_a,
    input  logic [1:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_a,
    output logic             rd_valid_b,
    output logic             sel_err,
    output logic [7:0]       wr_cnt
);

    // DELAY describes gate timing of the structural netlist only; the RTL
    // carries no delays. A negative value is meaningless, so it produces no
    // logic and is kept here only as a visible range marker.
    if (DELAY < 0) begin : g_delay_negative
    end

    localparam logic [1:0] SEL_NONE  = 2'd0;
    localparam logic [1:0] SEL_ONE   = 2'd1;
    localparam logic [1:0] SEL_MULTI = 2'd2;

    logic [WIDTH-1:0] mem [4];
    logic [3:0]       valid;
    logic [1:0]       sel_class;

    // Clearing the lowest set bit leaves a nonzero vector only when two or
    // more bits were set, which separates ONE from MULTI without a popcount.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        sel_class = SEL_NONE;
        if ((we_onehot & (we_onehot - 4'd1)) != 4'd0) begin
            sel_class = SEL_MULTI;
        end else if (we_onehot != 4'd0) begin
            sel_class = SEL_ONE;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the entry array is reset on purpose; reads of never-written
    // entries must return 0, so the storage cannot be left uninitialised.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            valid   <= 4'b0000;
            sel_err <= 1'b0;
            wr_cnt  <= 8'd0;
        end else begin
            if (sel_class == SEL_ONE) begin
                for (int i = 0; i < 4; i++) begin
                    if (we_onehot[i]) begin
                        mem[i] <= wr_data;
                    end
                end
                if (wr_cnt != 8'hFF) begin
                    wr_cnt <= wr_cnt + 8'd1;
                end
            end

            // A clear combined with a legal write leaves only the written
            // entry valid; the one-hot select doubles as that valid pattern.
            if (clr_valid) begin
                valid <= (sel_class == SEL_ONE) ? we_onehot : 4'b0000;
            end else if (sel_class == SEL_ONE) begin
                valid <= valid | we_onehot;
            end

            // Set has priority over clear so a fresh error is never lost.
            if (sel_class == SEL_MULTI) begin
                sel_err <= 1'b1;
            end else if (err_clr) begin
                sel_err <= 1'b0;
            end
        end
    end

    // Reads come straight from stored state: a same-cycle write is not
    // forwarded, so the old value is seen until the edge.
    assign rd_data_a  = mem[rd_addr_a];
    assign rd_data_b  = mem[rd_addr_b];
    assign rd_valid_a = valid[rd_addr_a];
    assign rd_valid_b = valid[rd_addr_b];

endmodule

// File: tb/tb_regbank4_w1h.sv
`timescale 1ps/1ps
// ---------------------------------------------------------------------------
// tb_regbank4_w1h
//   Directed sequence followed by randomized traffic, checked against a
//   behavioural model built from the bank's rules (popcount of the select,
//   saturating counter, sticky error).
// ---------------------------------------------------------------------------
module tb_regbank4_w1h;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [3:0]       we_onehot;
    logic [WIDTH-1:0] wr_data;
    logic             clr_valid;
    logic             err_clr;
    logic [1:0]       rd_addr_a;
    logic [1:0]       rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid_a;
    logic             rd_valid_b;
    logic             sel_err;
    logic [7:0]       wr_cnt;

    regbank4_w1h #(.WIDTH(WIDTH), .DELAY(50)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_onehot  (we_onehot),
        .wr_data    (wr_data),
        .clr_valid  (clr_valid),
        .err_clr    (err_clr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_valid_a (rd_valid_a),
        .rd_valid_b (rd_valid_b),
        .sel_err    (sel_err),
        .wr_cnt     (wr_cnt)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Reference model
    int m_data [4];
    bit m_valid [4];
    bit m_err;
    int m_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int n;
        int idx;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_data[i]  = 0;
                m_valid[i] = 1'b0;
            end
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            n   = $countones(we_onehot);
            idx = -1;
            for (int i = 0; i < 4; i++) if (we_onehot[i]) idx = i;
            if (clr_valid) for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
            if (n == 1) begin
                m_data[idx]  = int'(wr_data);
                m_valid[idx] = 1'b1;
                m_cnt        = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            if (n >= 2) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    endtask

    task automatic drive(input logic [3:0] we, input logic [7:0] d,
                         input logic cv, input logic ec, input logic rn);
        we_onehot = we;
        wr_data   = d;
        clr_valid = cv;
        err_clr   = ec;
        reset_n   = rn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Compares flags, counter and every entry through both ports.
    task automatic check_state(input string tag);
        chk({tag, ".sel_err"}, 32'(sel_err), 32'(m_err));
        chk({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(m_cnt));
        for (int a = 0; a < 4; a++) begin
            rd_addr_a = 2'(a);
            rd_addr_b = 2'(3 - a);
            #1;
            chk({tag, ".data_a"}, 32'(rd_data_a), 32'(m_data[a]));
            chk({tag, ".valid_a"}, 32'(rd_valid_a), 32'(m_valid[a]));
            chk({tag, ".data_b"}, 32'(rd_data_b), 32'(m_data[3 - a]));
            chk({tag, ".valid_b"}, 32'(rd_valid_b), 32'(m_valid[3 - a]));
        end
    endtask

    initial begin
        logic [3:0] we_r;
        int r;

        rd_addr_a = 2'd0;
        rd_addr_b = 2'd0;
        for (int i = 0; i < 4; i++) begin
            m_data[i]  = 0;
            m_valid[i] = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = 0;

        // Reset held for two edges, then released idle.
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("reset_idle");
        chk("reset_cnt_zero", 32'(wr_cnt), 32'd0);

        // Fill all four entries.
        for (int i = 0; i < 4; i++) begin
            drive(4'(1 << i), 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
        check_state("fill");
        chk("fill_cnt4", 32'(wr_cnt), 32'd4);
        rd_addr_a = 2'd3;
        #1;
        chk("fill_entry3", 32'(rd_data_a), 32'h44);

        // Same-cycle read of the entry being written.
        rd_addr_a = 2'd2;
        drive(4'b0100, 8'hA5, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rbw_before_edge", 32'(rd_data_a), 32'h33);
        tick();
        chk("rbw_after_edge", 32'(rd_data_a), 32'hA5);
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);

        // Multi-hot rejection, then set-wins and clear.
        drive(4'b0110, 8'hFF, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("multi");
        chk("multi_err_set", 32'(sel_err), 32'd1);
        chk("multi_cnt_held", 32'(wr_cnt), 32'd5);
        drive(4'b1010, 8'hEE, 1'b0, 1'b1, 1'b1);
        tick();
        chk("err_set_wins", 32'(sel_err), 32'd1);
        drive(4'b0000, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        chk("err_cleared", 32'(sel_err), 32'd0);
        check_state("after_err");

        // clr_valid together with a write to entry 0.
        drive(4'b0001, 8'h5A, 1'b1, 1'b0, 1'b1);
        tick();
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
        check_state("clrv");
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd1;
        #1;
        chk("clrv_entry0", 32'(rd_data_a), 32'h5A);
        chk("clrv_valid0", 32'(rd_valid_a), 32'd1);
        chk("clrv_valid1", 32'(rd_valid_b), 32'd0);
        chk("clrv_entry1", 32'(rd_data_b), 32'h22);

        // Randomized traffic.
        for (int c = 0; c < 200; c++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      we_r = 4'b0000;
            else if (r < 8) we_r = 4'(1 << $urandom_range(0, 3));
            else            we_r = 4'($urandom_range(0, 15)) | 4'(4'b0011 << $urandom_range(0, 2));
            drive(we_r, 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'b1);
            tick();
            check_state("rand");
        end

        // Saturation of the write counter.
        for (int c = 0; c < 300; c++) begin
            drive(4'(1 << $urandom_range(0, 3)), 8'($urandom), 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("sat_cnt", 32'(wr_cnt), 32'd255);
        check_state("sat");

        // Reset during a write discards the write.
        drive(4'b1000, 8'h77, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
        rd_addr_a = 2'd3;
        #1;
        chk("rst_entry3", 32'(rd_data_a), 32'd0);
        chk("rst_valid3", 32'(rd_valid_a), 32'd0);
        chk("rst_cnt", 32'(wr_cnt), 32'd0);
        check_state("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
